controla_movimento: RTL and testbench

//  Per-frame movement sequencer for a square object. Once per video frame it

---
 rtl/controla_movimento.sv | 177 +++++++++++++++++
 tb/tb_controla_movimento.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controla_movimento.sv
// Per-frame movement sequencer: proposes one axis step at a time to an external
// collision checker and commits only the steps the checker does not flag.
module controla_movimento #(
  parameter int X_INICIAL = 320,
  parameter int Y_INICIAL = 240,
  parameter int PASSO     = 2,
  parameter int LATENCIA  = 2
) (
  input  logic       VGA_clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       tecla_dir,
  input  logic       tecla_esq,
  input  logic       tecla_cima,
  input  logic       tecla_baixo,
  input  logic       colisao_max_x,
  input  logic       colisao_min_x,
  input  logic       colisao_max_y,
  input  logic       colisao_min_y,
  output logic [9:0] cand_x,
  output logic [8:0] cand_y,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic       ocupado,
  output logic       atualizado,
  output logic [3:0] bloqueado
);

  typedef enum logic [2:0] {
    IDLE,
    TESTA_X,
    ESPERA_X,
    AVALIA_X,
    TESTA_Y,
    ESPERA_Y,
    AVALIA_Y,
    FIM
  } estado_t;

  localparam int CW = $clog2(LATENCIA + 1);

  estado_t       estado_reg;
  logic [CW-1:0] espera_reg;
  logic          x_mov_reg, x_neg_reg;
  logic          y_mov_reg, y_neg_reg;

  // Clamped neighbours of the committed position
  logic [10:0] x_soma;
  logic [9:0]  y_soma;
  logic [9:0]  x_mais, x_menos;
  logic [8:0]  y_mais, y_menos;
  logic        x_colide, y_colide;
  logic        tecla_x, tecla_y;

  assign x_soma  = {1'b0, pos_x} + 11'(PASSO);
  assign y_soma  = {1'b0, pos_y} + 10'(PASSO);
  assign x_mais  = x_soma[10] ? 10'd1023 : x_soma[9:0];
  assign y_mais  = y_soma[9]  ? 9'd511   : y_soma[8:0];
  assign x_menos = (pos_x < 10'(PASSO)) ? 10'd0 : pos_x - 10'(PASSO);
  assign y_menos = (pos_y < 9'(PASSO))  ? 9'd0  : pos_y - 9'(PASSO);

  // Only the flag facing the direction of motion matters
  assign x_colide = x_neg_reg ? colisao_min_x : colisao_max_x;
  assign y_colide = y_neg_reg ? colisao_min_y : colisao_max_y;

  assign tecla_x = tecla_dir ^ tecla_esq;
  assign tecla_y = tecla_baixo ^ tecla_cima;

  always_ff @(posedge VGA_clk) begin
    if (!rst_n) begin
      estado_reg <= IDLE;
      espera_reg <= '0;
      x_mov_reg  <= 1'b0;
      x_neg_reg  <= 1'b0;
      y_mov_reg  <= 1'b0;
      y_neg_reg  <= 1'b0;
      pos_x      <= 10'(X_INICIAL);
      pos_y      <= 9'(Y_INICIAL);
      cand_x     <= 10'(X_INICIAL);
      cand_y     <= 9'(Y_INICIAL);
      ocupado    <= 1'b0;
      atualizado <= 1'b0;
      bloqueado  <= 4'b0000;
    end else begin
      atualizado <= 1'b0;
      case (estado_reg)
        IDLE: begin
          cand_x <= pos_x;
          cand_y <= pos_y;
          if (frame_tick) begin
            x_mov_reg <= tecla_x;
            x_neg_reg <= tecla_esq & ~tecla_dir;
            y_mov_reg <= tecla_y;
            y_neg_reg <= tecla_cima & ~tecla_baixo;
            bloqueado <= 4'b0000;
            ocupado   <= 1'b1;
            if (tecla_x || tecla_y) begin
              estado_reg <= TESTA_X;
            end else begin
              estado_reg <= FIM;
              atualizado <= 1'b1;
            end
          end
        end

        TESTA_X: begin
          if (!x_mov_reg) begin
            estado_reg <= TESTA_Y;
          end else begin
            cand_x     <= x_neg_reg ? x_menos : x_mais;
            cand_y     <= pos_y;
            espera_reg <= CW'(LATENCIA);
            estado_reg <= ESPERA_X;
          end
        end

        ESPERA_X: begin
          espera_reg <= espera_reg - 1'b1;
          if (espera_reg == CW'(1)) estado_reg <= AVALIA_X;
        end

        AVALIA_X: begin
          if (x_colide) begin
            if (x_neg_reg) bloqueado[2] <= 1'b1;
            else           bloqueado[3] <= 1'b1;
            cand_x <= pos_x;
          end else begin
            pos_x <= cand_x;
          end
          estado_reg <= TESTA_Y;
        end

        TESTA_Y: begin
          if (!y_mov_reg) begin
            estado_reg <= FIM;
            atualizado <= 1'b1;
          end else begin
            cand_y     <= y_neg_reg ? y_menos : y_mais;
            cand_x     <= pos_x;
            espera_reg <= CW'(LATENCIA);
            estado_reg <= ESPERA_Y;
          end
        end

        ESPERA_Y: begin
          espera_reg <= espera_reg - 1'b1;
          if (espera_reg == CW'(1)) estado_reg <= AVALIA_Y;
        end

        AVALIA_Y: begin
          if (y_colide) begin
            if (y_neg_reg) bloqueado[0] <= 1'b1;
            else           bloqueado[1] <= 1'b1;
            cand_y <= pos_y;
          end else begin
            pos_y <= cand_y;
          end
          estado_reg <= FIM;
          atualizado <= 1'b1;
        end

        FIM: begin
          cand_x     <= pos_x;
          cand_y     <= pos_y;
          ocupado    <= 1'b0;
          estado_reg <= IDLE;
        end

        default: begin
          ocupado    <= 1'b0;
          estado_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controla_movimento.sv
// Randomised bench for controla_movimento: a wall-based collision checker with
// LAT-cycle latency and a per-frame position model derived from the step rules.
module tb_controla_movimento;
  localparam int LAT = 2;
  localparam int P   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       t_dir = 1'b0, t_esq = 1'b0, t_cima = 1'b0, t_baixo = 1'b0;
  logic       c_max_x, c_min_x, c_max_y, c_min_y;
  logic [9:0] cand_x, pos_x;
  logic [8:0] cand_y, pos_y;
  logic       ocupado, atualizado;
  logic [3:0] bloqueado;

  controla_movimento #(
    .X_INICIAL(320), .Y_INICIAL(240), .PASSO(P), .LATENCIA(LAT)
  ) dut (
    .VGA_clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .tecla_dir(t_dir), .tecla_esq(t_esq), .tecla_cima(t_cima), .tecla_baixo(t_baixo),
    .colisao_max_x(c_max_x), .colisao_min_x(c_min_x),
    .colisao_max_y(c_max_y), .colisao_min_y(c_min_y),
    .cand_x(cand_x), .cand_y(cand_y), .pos_x(pos_x), .pos_y(pos_y),
    .ocupado(ocupado), .atualizado(atualizado), .bloqueado(bloqueado)
  );

  always #5 clk = ~clk;

  // Checker: walls judge the candidate seen LAT cycles ago; noise bits are stale flags
  int   wx_lo = 0, wx_hi = 1023, wy_lo = 0, wy_hi = 511;
  logic n_mx = 0, n_nx = 0, n_my = 0, n_ny = 0;
  logic [9:0] dly_x [LAT];
  logic [8:0] dly_y [LAT];

  always @(posedge clk) begin
    dly_x[0] <= cand_x;
    dly_y[0] <= cand_y;
    for (int i = 1; i < LAT; i++) begin
      dly_x[i] <= dly_x[i-1];
      dly_y[i] <= dly_y[i-1];
    end
  end

  assign c_max_x = (int'(dly_x[LAT-1]) > wx_hi) | n_mx;
  assign c_min_x = (int'(dly_x[LAT-1]) < wx_lo) | n_nx;
  assign c_max_y = (int'(dly_y[LAT-1]) > wy_hi) | n_my;
  assign c_min_y = (int'(dly_y[LAT-1]) < wy_lo) | n_ny;

  int         mx = 320, my = 240;
  logic [3:0] mblk = 4'b0000;
  int         passed = 0, total = 0, frames = 0;
  int         upd_cnt;
  int         esp_x, esp_y_x, esp_y_y;

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // One frame: tick, optional extra tick mid-sequence, model update and checks
  task automatic run_frame(input logic d, input logic e, input logic c, input logic b,
                           input bit extra);
    int kx, ky, ex_cx, ex_cy, n, yi;
    bit hit;
    kx = (d && !e) ? 1 : ((e && !d) ? -1 : 0);
    ky = (b && !c) ? 1 : ((c && !b) ? -1 : 0);
    mblk = 4'b0000;
    ex_cx = 0;
    ex_cy = 0;
    if (kx != 0) begin
      ex_cx = clampi(mx + kx * P, 1023);
      hit = (kx > 0) ? (ex_cx > wx_hi || n_mx) : (ex_cx < wx_lo || n_nx);
      if (hit) mblk[(kx > 0) ? 3 : 2] = 1'b1;
      else     mx = ex_cx;
    end
    if (ky != 0) begin
      ex_cy = clampi(my + ky * P, 511);
      hit = (ky > 0) ? (ex_cy > wy_hi || n_my) : (ex_cy < wy_lo || n_ny);
      if (hit) mblk[(ky > 0) ? 1 : 0] = 1'b1;
      else     my = ex_cy;
    end
    yi = (kx != 0) ? LAT + 4 : 3;

    @(negedge clk);
    frame_tick = 1'b1;
    t_dir = d; t_esq = e; t_cima = c; t_baixo = b;
    @(negedge clk);
    frame_tick = 1'b0;
    {t_dir, t_esq, t_cima, t_baixo} = 4'($urandom);
    upd_cnt = 0;
    esp_x = -1; esp_y_x = -1; esp_y_y = -1;
    n = 1;
    while (n <= 60) begin
      if (atualizado) upd_cnt++;
      if (n == 2) esp_x = int'(cand_x);
      if (n == yi) begin
        esp_y_x = int'(cand_x);
        esp_y_y = int'(cand_y);
      end
      if (!ocupado) break;
      frame_tick = (extra && n == 3);
      @(negedge clk);
      n++;
    end
    frame_tick = 1'b0;
    frames++;
    $display("frame %0d keys(d,e,c,b)=%b%b%b%b pos=(%0d,%0d) bloqueado=%b upd=%0d",
             frames, d, e, c, b, pos_x, pos_y, bloqueado, upd_cnt);

    total++;
    if (n > 60) $display("FAIL seq_timeout: frame %0d ocupado still %b after 60 cycles", frames, ocupado);
    else passed++;
    total++;
    if (pos_x !== 10'(mx)) $display("FAIL pos_x: got %0d expected %0d", pos_x, mx);
    else passed++;
    total++;
    if (pos_y !== 9'(my)) $display("FAIL pos_y: got %0d expected %0d", pos_y, my);
    else passed++;
    total++;
    if (bloqueado !== mblk) $display("FAIL bloqueado: got %b expected %b", bloqueado, mblk);
    else passed++;
    total++;
    if (upd_cnt != 1) $display("FAIL atualizado_pulses: got %0d expected 1", upd_cnt);
    else passed++;
    if (kx != 0) begin
      total++;
      if (esp_x != ex_cx) $display("FAIL cand_x_espera_x: got %0d expected %0d", esp_x, ex_cx);
      else passed++;
    end
    if (ky != 0) begin
      total++;
      if (esp_y_y != ex_cy || esp_y_x != mx)
        $display("FAIL cand_espera_y: got (%0d,%0d) expected (%0d,%0d)", esp_y_x, esp_y_y, mx, ex_cy);
      else passed++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (ocupado !== 1'b0 || cand_x !== 10'(mx) || cand_y !== 9'(my))
      $display("FAIL idle_after: ocupado=%b cand=(%0d,%0d) expected 0 (%0d,%0d)",
               ocupado, cand_x, cand_y, mx, my);
    else passed++;
  endtask

  task automatic test_reset();
    int upd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    upd = 0;
    repeat (10) begin
      @(negedge clk);
      if (atualizado) upd++;
    end
    total++;
    if (pos_x !== 10'd320 || pos_y !== 9'd240)
      $display("FAIL reset_pos: got (%0d,%0d) expected (320,240)", pos_x, pos_y);
    else passed++;
    total++;
    if (cand_x !== 10'd320 || cand_y !== 9'd240)
      $display("FAIL reset_cand: got (%0d,%0d) expected (320,240)", cand_x, cand_y);
    else passed++;
    total++;
    if (ocupado !== 1'b0 || bloqueado !== 4'b0000 || upd != 0)
      $display("FAIL reset_flags: ocupado=%b bloqueado=%b upd=%0d expected 0 0000 0", ocupado, bloqueado, upd);
    else passed++;
  endtask

  task automatic test_step_right();
    run_frame(1, 0, 0, 0, 0);
    total++;
    if (esp_x != 322 || pos_x !== 10'd322)
      $display("FAIL step_right: cand=%0d pos=%0d expected 322 322", esp_x, pos_x);
    else passed++;
  endtask

  task automatic test_block_right();
    wx_hi = 620;
    while (mx < 620) run_frame(1, 0, 0, 0, 0);
    run_frame(1, 0, 0, 0, 0);
    total++;
    if (pos_x !== 10'd620 || bloqueado !== 4'b1000)
      $display("FAIL block_right: pos_x=%0d bloqueado=%b expected 620 1000", pos_x, bloqueado);
    else passed++;
    wx_hi = 1023;
  endtask

  task automatic test_clamp_min();
    while (mx < 1023 || my < 511) run_frame(mx < 1023, 0, 0, my < 511, 0);
    while (my > 1) run_frame(0, mx > 1, 1, 0, 0);
    while (mx > 1) run_frame(0, 1, 0, 0, 0);
    wx_lo = 1;
    wy_lo = 1;
    run_frame(0, 1, 1, 0, 0);
    total++;
    if (esp_x != 0 || esp_y_y != 0)
      $display("FAIL clamp_cand: got (%0d,%0d) expected (0,0)", esp_x, esp_y_y);
    else passed++;
    total++;
    if (pos_x !== 10'd1 || pos_y !== 9'd1 || bloqueado !== 4'b0101)
      $display("FAIL clamp_block: pos=(%0d,%0d) bloqueado=%b expected (1,1) 0101", pos_x, pos_y, bloqueado);
    else passed++;
    wx_lo = 0;
    wy_lo = 0;
  endtask

  task automatic test_both_x_keys();
    int px, py;
    px = mx;
    py = my;
    run_frame(1, 1, 0, 1, 1);
    total++;
    if (pos_x !== 10'(px) || pos_y !== 9'(py + P) || upd_cnt != 1)
      $display("FAIL both_x_keys: pos=(%0d,%0d) upd=%0d expected (%0d,%0d) 1", pos_x, pos_y, upd_cnt, px, py + P);
    else passed++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 60; f++) begin
      wx_lo = mx - int'($urandom_range(0, 3)); if (wx_lo < 0) wx_lo = 0;
      wy_lo = my - int'($urandom_range(0, 3)); if (wy_lo < 0) wy_lo = 0;
      wx_hi = mx + int'($urandom_range(0, 3));
      wy_hi = my + int'($urandom_range(0, 3));
      n_mx = ($urandom_range(0, 7) == 0);
      n_nx = ($urandom_range(0, 7) == 0);
      n_my = ($urandom_range(0, 7) == 0);
      n_ny = ($urandom_range(0, 7) == 0);
      run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    {n_mx, n_nx, n_my, n_ny} = 4'b0000;
    wx_lo = 0; wx_hi = 1023; wy_lo = 0; wy_hi = 511;
  endtask

  task automatic test_reset_mid();
    int n, upd;
    @(negedge clk);
    frame_tick = 1'b1;
    t_dir = 1; t_esq = 0; t_cima = 0; t_baixo = 1;
    @(negedge clk);
    frame_tick = 1'b0;
    n = 1;
    while (n < LAT + 4) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mx = 320;
    my = 240;
    total++;
    if (pos_x !== 10'd320 || pos_y !== 9'd240 || ocupado !== 1'b0 || atualizado !== 1'b0)
      $display("FAIL reset_mid: pos=(%0d,%0d) ocupado=%b atualizado=%b expected (320,240) 0 0",
               pos_x, pos_y, ocupado, atualizado);
    else passed++;
    upd = 0;
    repeat (2 * (LAT + 2) + 2) begin
      @(negedge clk);
      if (atualizado) upd++;
    end
    total++;
    if (upd != 0 || ocupado !== 1'b0)
      $display("FAIL reset_mid_quiet: atualizado pulses=%0d ocupado=%b expected 0 0", upd, ocupado);
    else passed++;
    run_frame(0, 1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_step_right();
    test_block_right();
    test_clamp_min();
    test_both_x_keys();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
